// File: rtl/apb_slave_bank.sv
// APB target bank: NSLV independent register-file slaves sharing one APB port,
// with a fixed number of wait states and pslverr on bad accesses.
module apb_slave_bank #(
  parameter int NSLV        = 3,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic [NSLV-1:0] pselx,
  input  logic            penable,
  input  logic            pwrite,
  input  logic [AW-1:0]   paddr,
  input  logic [DW-1:0]   pwdata,
  output logic [DW-1:0]   prdata,
  output logic            pready,
  output logic            pslverr
);

  localparam int WW = $clog2(DEPTH);
  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam logic [AW-1:0] WINDOW = AW'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, SETUP_SEEN, ACCESS} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   slv_q, slv_d, slv_dec;
  logic [WW-1:0]   word_q, word_d, word_in;
  logic            wr_q, wr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            err_q, err_d, err_in;
  logic [3:0]      cnt_q, cnt_d;
  logic [DW-1:0]   prdata_d;
  logic            pready_d, pslverr_d;
  logic            setup, mem_we;
  logic [DW-1:0]   rd_live, rd_held;
  logic [DW-1:0]   mem [NSLV][DEPTH];

  assign setup   = (|pselx) & ~penable;
  assign word_in = paddr[WW+1:2];
  assign err_in  = (paddr[1:0] != 2'b00) | (paddr >= WINDOW) | ($countones(pselx) > 1);
  assign rd_live = mem[slv_dec][word_in];
  assign rd_held = mem[slv_q][word_q];

  // Index choice on a multi-hot select is irrelevant: such a transfer is an error.
  always_comb begin
    slv_dec = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (pselx[i]) slv_dec = SW'(i);
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= IDLE;
      slv_q   <= '0;
      word_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state_q <= state_d;
      slv_q   <= slv_d;
      word_q  <= word_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      prdata  <= prdata_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    slv_d     = slv_q;
    word_d    = word_q;
    wr_d      = wr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          slv_d   = slv_dec;
          word_d  = word_in;
          wr_d    = pwrite;
          wdata_d = pwdata;
          err_d   = err_in;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
          if (WAIT_STATES == 0) begin
            pready_d  = 1'b1;
            pslverr_d = err_in;
            prdata_d  = (!pwrite && !err_in) ? rd_live : '0;
          end
        end
      end
      ACCESS: begin
        if (pready) begin
          mem_we  = wr_q & ~err_q;
          state_d = IDLE;
        end else if (!(|pselx)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d  = 1'b1;
            pslverr_d = err_q;
            prdata_d  = (!wr_q && !err_q) ? rd_held : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int unsigned s = 0; s < NSLV; s++) begin
        for (int unsigned w = 0; w < DEPTH; w++) begin
          mem[s][w] <= '0;
        end
      end
    end else if (mem_we) begin
      mem[slv_q][word_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench: one bank with no wait states (u_ws0) and one with three (u_ws3),
// sharing penable/pwrite/paddr/pwdata but each with its own pselx.
module tb_apb_slave_bank;

  logic        hclk;
  logic        hresetn;
  logic [2:0]  psel0, psel3;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata0, prdata3;
  logic        pready0, pready3;
  logic        pslverr0, pslverr3;

  int n_tests = 0;
  int n_fail  = 0;

  apb_slave_bank #(.NSLV(3), .AW(32), .DW(32), .DEPTH(16), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hresetn(hresetn), .pselx(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
  );

  apb_slave_bank #(.NSLV(3), .AW(32), .DW(32), .DEPTH(16), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hresetn(hresetn), .pselx(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge hclk);
      psel0   = '0;
      psel3   = '0;
      penable = 1'b0;
    end
  endtask

  // One APB transfer; returns mid-way through the completion cycle so a
  // following call issues its SETUP straight after the completion edge.
  task automatic xfer(input bit d3, input logic [2:0] sel, input logic [31:0] addr,
                      input bit wr, input logic [31:0] wdata, input int waits,
                      input logic [31:0] exp_rd, input bit exp_err, input string tag);
    @(negedge hclk);
    psel0   = d3 ? 3'b000 : sel;
    psel3   = d3 ? sel : 3'b000;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(negedge hclk);
    penable = 1'b1;
    for (int c = 0; c <= waits; c++) begin
      if (c > 0) @(negedge hclk);
      if (c < waits) begin
        chk({tag, "_wait_pready"}, {31'b0, d3 ? pready3 : pready0}, 32'd0);
      end else begin
        chk({tag, "_pready"},  {31'b0, d3 ? pready3 : pready0}, 32'd1);
        chk({tag, "_pslverr"}, {31'b0, d3 ? pslverr3 : pslverr0}, {31'b0, exp_err});
        chk({tag, "_prdata"},  d3 ? prdata3 : prdata0, exp_rd);
      end
    end
  endtask

  initial begin
    hresetn = 1'b0;
    psel0   = '0;
    psel3   = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (2) @(negedge hclk);
    chk("rst_prdata0",  prdata0, 32'd0);
    chk("rst_pready0",  {31'b0, pready0}, 32'd0);
    chk("rst_pslverr0", {31'b0, pslverr0}, 32'd0);
    chk("rst_pready3",  {31'b0, pready3}, 32'd0);
    hresetn = 1'b1;
    idle(1);

    // No wait states: write then read slave1 word 2
    xfer(0, 3'b010, 32'h08, 1, 32'hDEADBEEF, 0, 32'h0, 0, "ws0_wr");
    idle(1);
    xfer(0, 3'b010, 32'h08, 0, 32'h0, 0, 32'hDEADBEEF, 0, "ws0_rd");
    idle(1);

    // Three wait states
    xfer(1, 3'b001, 32'h04, 1, 32'h1234, 3, 32'h0, 0, "ws3_wr");
    idle(1);
    xfer(1, 3'b001, 32'h04, 0, 32'h0, 3, 32'h00001234, 0, "ws3_rd");
    idle(1);
    xfer(1, 3'b100, 32'h04, 0, 32'h0, 3, 32'h0, 0, "ws3_rd_s2");
    idle(1);

    // Error responses; none may disturb memory
    xfer(0, 3'b010, 32'h42, 1, 32'h55, 0, 32'h0, 1, "err_misal");
    idle(1);
    xfer(0, 3'b010, 32'h40, 1, 32'h55, 0, 32'h0, 1, "err_window");
    idle(1);
    xfer(0, 3'b011, 32'h08, 1, 32'h55, 0, 32'h0, 1, "err_multi");
    idle(1);
    xfer(0, 3'b010, 32'h40, 0, 32'h0, 0, 32'h0, 1, "err_rd_window");
    idle(1);
    xfer(0, 3'b010, 32'h08, 0, 32'h0, 0, 32'hDEADBEEF, 0, "err_chk_s1w2");
    idle(1);
    xfer(0, 3'b001, 32'h08, 0, 32'h0, 0, 32'h0, 0, "err_chk_s0w2");
    idle(1);
    xfer(0, 3'b010, 32'h00, 0, 32'h0, 0, 32'h0, 0, "err_chk_s1w0");
    idle(1);

    // Back-to-back write/read with no idle cycle in between
    xfer(0, 3'b100, 32'h0C, 1, 32'hA5A5F00D, 0, 32'h0, 0, "b2b0_wr");
    xfer(0, 3'b100, 32'h0C, 0, 32'h0, 0, 32'hA5A5F00D, 0, "b2b0_rd");
    xfer(1, 3'b010, 32'h10, 1, 32'hCAFE0001, 3, 32'h0, 0, "b2b3_wr");
    xfer(1, 3'b010, 32'h10, 0, 32'h0, 3, 32'hCAFE0001, 0, "b2b3_rd");
    idle(1);

    // pselx dropped mid-ACCESS aborts the write
    @(negedge hclk);
    psel3 = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h77;
    @(negedge hclk);
    penable = 1'b1;
    chk("abort_wait", {31'b0, pready3}, 32'd0);
    @(negedge hclk);
    psel3 = '0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk("abort_idle_pready", {31'b0, pready3}, 32'd0);
    end
    xfer(1, 3'b100, 32'h08, 0, 32'h0, 3, 32'h0, 0, "abort_rd");
    idle(1);

    // Reset during a wait-stated write
    @(negedge hclk);
    psel3 = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h3C; pwdata = 32'hBAD0BAD0;
    @(negedge hclk);
    penable = 1'b1;
    @(negedge hclk);
    hresetn = 1'b0;
    #1;
    chk("midrst_pready",  {31'b0, pready3}, 32'd0);
    chk("midrst_prdata",  prdata3, 32'd0);
    chk("midrst_pslverr", {31'b0, pslverr3}, 32'd0);
    @(negedge hclk);
    psel3 = '0; penable = 1'b0;
    hresetn = 1'b1;
    idle(1);
    xfer(1, 3'b001, 32'h3C, 0, 32'h0, 3, 32'h0, 0, "midrst_rd_w15");
    idle(1);
    xfer(1, 3'b001, 32'h04, 0, 32'h0, 3, 32'h0, 0, "midrst_rd_w1");
    idle(1);

    // penable without a SETUP phase is ignored
    @(negedge hclk);
    psel3 = 3'b001; penable = 1'b1; pwrite = 1'b0; paddr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      @(negedge hclk);
      chk("nosetup_pready", {31'b0, pready3}, 32'd0);
    end
    idle(1);

    // Slave isolation on word 15
    xfer(0, 3'b001, 32'h3C, 1, 32'h11110000, 0, 32'h0, 0, "iso_wr0");
    xfer(0, 3'b010, 32'h3C, 1, 32'h22220001, 0, 32'h0, 0, "iso_wr1");
    xfer(0, 3'b100, 32'h3C, 1, 32'h33330002, 0, 32'h0, 0, "iso_wr2");
    idle(1);
    xfer(0, 3'b001, 32'h3C, 0, 32'h0, 0, 32'h11110000, 0, "iso_rd0");
    xfer(0, 3'b010, 32'h3C, 0, 32'h0, 0, 32'h22220001, 0, "iso_rd1");
    xfer(0, 3'b100, 32'h3C, 0, 32'h0, 0, 32'h33330002, 0, "iso_rd2");
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
